// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM state encoding, the drain length after HLT
// and the hard-wired zero register number.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    // Cycles the pipeline is drained after HLT before reporting halted.
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    // Register 0 always reads as zero, so writes to it never create a hazard.
    localparam logic [3:0] REG_ZERO = 4'h0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: flags an instruction in decode that reads the destination
// of a load currently in D/X. Purely combinational.
module hazard_cmp
    import cpu_pkg::*;
(
    input  logic       fd_valid,
    input  logic [3:0] fd_rs,
    input  logic [3:0] fd_rt,
    input  logic       fd_uses_rt,
    input  logic       dx_memread,
    input  logic [3:0] dx_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (dx_rt == fd_rs);
    assign rt_match = fd_uses_rt & (dx_rt == fd_rt);

    // A load into the zero register produces nothing worth waiting for.
    assign load_use = fd_valid & dx_memread & (dx_rt != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: 1-cycle load-use stall, branch flush, and HLT
// drain/halt sequencing. All outputs are registered.
// Optional build macro HAZARD_STATS_EN adds a saturating load-use stall counter
// output stall_cnt.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fd_valid,
    input  logic [3:0]  fd_rs,
    input  logic [3:0]  fd_rt,
    input  logic        fd_uses_rt,
    input  logic        fd_halt,
    input  logic        dx_memread,
    input  logic [3:0]  dx_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        fd_write,
    output logic        fd_flush,
    output logic        dx_flush,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        halted
);

    state_t     state;
    logic [1:0] drain_cnt;
    logic       load_use;

    hazard_cmp u_cmp (
        .fd_valid   (fd_valid),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rt (fd_uses_rt),
        .dx_memread (dx_memread),
        .dx_rt      (dx_rt),
        .load_use   (load_use)
    );

    // FSM: next state, drain counter and the registered control outputs.
    // Branch resolution has priority over load-use and HLT; a taken branch
    // while draining means the HLT was speculative, so the drain is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            pc_write  <= 1'b1;
            fd_write  <= 1'b1;
            fd_flush  <= 1'b0;
            dx_flush  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b11110;
                    end else if (load_use) begin
                        // Hold PC and F/D for one cycle, bubble into D/X.
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b00010;
                    end else if (fd_valid && fd_halt) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_CYCLES;
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b00010;
                    end else begin
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b11000;
                    end
                end
                DRAIN: begin
                    if (branch_taken) begin
                        state     <= RUN;
                        drain_cnt <= 2'd0;
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b11110;
                    end else if (drain_cnt == 2'd1) begin
                        state     <= HALTED;
                        drain_cnt <= 2'd0;
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b00011;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                        {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b00010;
                    end
                end
                HALTED: begin
                    // Only reset leaves HALTED.
                    {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b00011;
                end
                default: begin
                    state     <= RUN;
                    drain_cnt <= 2'd0;
                    {pc_write, fd_write, fd_flush, dx_flush, halted} <= 5'b11000;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    // Count load-use stall cycles taken in RUN, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (state == RUN && load_use && !branch_taken && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit. Each cycle the expected registered outputs
// {pc_write, fd_write, fd_flush, dx_flush, halted} are pushed to a scoreboard
// when stimulus is driven and popped after the following rising edge.
// With HAZARD_STATS_EN defined the stall counter is checked too.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fd_valid;
    logic [3:0]  fd_rs;
    logic [3:0]  fd_rt;
    logic        fd_uses_rt;
    logic        fd_halt;
    logic        dx_memread;
    logic [3:0]  dx_rt;
    logic        branch_taken;
    logic        pc_write;
    logic        fd_write;
    logic        fd_flush;
    logic        dx_flush;
    logic        halted;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    int          exp_stall;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11110;
    localparam logic [4:0] O_DRAIN = 5'b00010;
    localparam logic [4:0] O_HALT  = 5'b00011;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fd_valid     (fd_valid),
        .fd_rs        (fd_rs),
        .fd_rt        (fd_rt),
        .fd_uses_rt   (fd_uses_rt),
        .fd_halt      (fd_halt),
        .dx_memread   (dx_memread),
        .dx_rt        (dx_rt),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .fd_write     (fd_write),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
`ifdef HAZARD_STATS_EN
        .stall_cnt    (stall_cnt),
`endif
        .halted       (halted)
    );

    // Drive one cycle of stimulus on the falling edge and queue its expected
    // outputs; after the next rising edge pop and compare.
    task automatic cycle(input logic r, input logic v, input logic [3:0] rs,
                         input logic [3:0] rt, input logic urt, input logic h,
                         input logic mr, input logic [3:0] drt, input logic br,
                         input logic [4:0] exp_v, input string name);
        exp_t e;
        exp_t got;
        logic [4:0] obs;
        @(negedge clk);
        rst = r; fd_valid = v; fd_rs = rs; fd_rt = rt; fd_uses_rt = urt;
        fd_halt = h; dx_memread = mr; dx_rt = drt; branch_taken = br;
        e.v = exp_v;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        obs = {pc_write, fd_write, fd_flush, dx_flush, halted};
        checks++;
        if (obs !== got.v) begin
            failures++;
            $display("FAIL %s: {pc_write,fd_write,fd_flush,dx_flush,halted} got %b expected %b",
                     got.name, obs, got.v);
        end else begin
            $display("ok   %s: outputs %b", got.name, obs);
        end
    endtask

    task automatic idle(input logic [4:0] exp_v, input string name);
        cycle(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, exp_v, name);
    endtask

    task automatic do_reset(input string name);
        cycle(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, O_RUN, name);
`ifdef HAZARD_STATS_EN
        exp_stall = 0;
`endif
    endtask

    task automatic check_stats(input string name);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== exp_stall[15:0]) begin
            failures++;
            $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, exp_stall);
        end else begin
            $display("ok   %s: stall_cnt %0d", name, stall_cnt);
        end
`else
        $display("note %s: stall counter not built", name);
`endif
    endtask

    task automatic test_reset();
        do_reset("reset");
        idle(O_RUN, "after_reset_idle");
        check_stats("reset_stall_cnt");
    endtask

    task automatic test_load_use_rs();
        cycle(0, 1, 4'h3, 4'h0, 0, 0, 1, 4'h3, 0, O_STALL, "load_use_rs_stall");
`ifdef HAZARD_STATS_EN
        exp_stall++;
`endif
        idle(O_RUN, "load_use_rs_resume");
        check_stats("load_use_rs_cnt");
    endtask

    task automatic test_reg_zero();
        cycle(0, 1, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, O_RUN, "reg_zero_no_stall");
        check_stats("reg_zero_cnt");
    endtask

    task automatic test_uses_rt();
        cycle(0, 1, 4'h2, 4'h5, 0, 0, 1, 4'h5, 0, O_RUN,   "rt_unused_no_stall");
        cycle(0, 1, 4'h2, 4'h5, 1, 0, 1, 4'h5, 0, O_STALL, "rt_used_stall");
`ifdef HAZARD_STATS_EN
        exp_stall++;
`endif
        // Load present but decode slot invalid: no stall.
        cycle(0, 0, 4'h5, 4'h5, 1, 0, 1, 4'h5, 0, O_RUN,   "invalid_fd_no_stall");
        check_stats("uses_rt_cnt");
    endtask

    task automatic test_branch_vs_load();
        cycle(0, 1, 4'h7, 4'h0, 0, 0, 1, 4'h7, 1, O_FLUSH, "branch_beats_load");
        idle(O_RUN, "branch_resume");
        check_stats("branch_load_cnt");
    endtask

    task automatic test_halt_drain();
        cycle(0, 1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, O_DRAIN, "halt_drain1");
        idle(O_DRAIN, "halt_drain2");
        idle(O_DRAIN, "halt_drain3");
        idle(O_HALT,  "halted_1");
        cycle(0, 1, 4'h3, 4'h0, 0, 0, 1, 4'h3, 1, O_HALT, "halted_ignores_branch");
        idle(O_HALT,  "halted_2");
        check_stats("halt_cnt");
        do_reset("reset_from_halted");
        idle(O_RUN, "run_after_halted");
    endtask

    task automatic test_drain_branch();
        cycle(0, 1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, O_DRAIN, "spec_halt_enter");
        idle(O_DRAIN, "spec_drain_first");
        cycle(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, O_FLUSH, "drain_branch_cancel");
        for (int i = 0; i < 4; i++) idle(O_RUN, $sformatf("after_cancel_%0d", i));
    endtask

    task automatic test_load_then_halt();
        cycle(0, 1, 4'h4, 4'h0, 0, 1, 1, 4'h4, 0, O_STALL, "load_halt_stall");
`ifdef HAZARD_STATS_EN
        exp_stall++;
`endif
        cycle(0, 1, 4'h4, 4'h0, 0, 1, 0, 4'h4, 0, O_DRAIN, "load_halt_drain1");
        idle(O_DRAIN, "load_halt_drain2");
        check_stats("load_halt_cnt");
        // Reset mid-drain aborts it; no halt should follow.
        do_reset("reset_in_drain");
        for (int i = 0; i < 4; i++) idle(O_RUN, $sformatf("no_pending_drain_%0d", i));
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 6; i++) begin
            cycle(0, 1, 4'(i), 4'h0, 0, 0, 1, 4'(i), 0, O_STALL, $sformatf("b2b_stall_%0d", i));
`ifdef HAZARD_STATS_EN
            exp_stall++;
`endif
        end
        idle(O_RUN, "b2b_resume");
        check_stats("b2b_cnt");
    endtask

    initial begin
        rst = 1'b1; fd_valid = 0; fd_rs = 0; fd_rt = 0; fd_uses_rt = 0;
        fd_halt = 0; dx_memread = 0; dx_rt = 0; branch_taken = 0;
`ifdef HAZARD_STATS_EN
        exp_stall = 0;
`endif
        test_reset();
        test_load_use_rs();
        test_reg_zero();
        test_uses_rt();
        test_branch_vs_load();
        test_back_to_back();
        test_halt_drain();
        test_drain_branch();
        test_load_then_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
